// File: rtl/loproc_irq_ctrl_pkg.sv
// Shared definitions for the loproc interrupt sequencer: FSM states,
// config register offsets and parameter defaults.
package loproc_irq_ctrl_pkg;

  localparam int          INSTRUCTION_WIDTH = 32;
  localparam int          VEC_SHIFT_DEF     = 4;
  localparam logic [31:0] VEC_BASE_DEF      = 32'h5000_2000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_SERVICE  = 3'd3,
    ST_RETURN   = 3'd4
  } irq_state_t;

  typedef enum logic [1:0] {
    CFG_MASK  = 2'd0,
    CFG_VBASE = 2'd1,
    CFG_GEN   = 2'd2,
    CFG_CLR   = 2'd3
  } cfg_addr_t;

endpackage

// File: rtl/loproc_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module loproc_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic               o_valid,
  output logic [4:0]         o_id
);

  // Scanning from the top down lets the lowest index overwrite last.
  always_comb begin
    o_valid = 1'b0;
    o_id    = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = 5'(i);
      end
    end
  end

endmodule

// File: rtl/loproc_irq_ctrl.sv
// Interrupt sequencer beside loproc_pc: latches edges, masks/prioritises,
// dispatches at a safe fetch boundary and replays the return address on iret.
module loproc_irq_ctrl
  import loproc_irq_ctrl_pkg::*;
#(
  parameter int                NUM_IRQ      = 8,
  parameter int                ADDR_W       = INSTRUCTION_WIDTH,
  parameter int                VEC_SHIFT    = VEC_SHIFT_DEF,
  parameter logic [ADDR_W-1:0] VEC_BASE_RST = ADDR_W'(VEC_BASE_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  i_irq_src,
  input  logic                i_cfg_we,
  input  logic [1:0]          i_cfg_addr,
  input  logic [ADDR_W-1:0]   i_cfg_wdata,
  input  logic                i_pc_load,
  input  logic [1:0]          i_pc_jump,
  input  logic [ADDR_W-1:0]   i_pc_next_addr,
  input  logic                i_iret,
  output logic                o_irq_interrupt,
  output logic [ADDR_W-1:0]   o_irq_vector_addr,
  output logic [ADDR_W-1:0]   o_epc,
  output logic                o_ret_jump,
  output logic [ADDR_W-1:0]   o_ret_addr,
  output logic                o_irq_active,
  output logic [4:0]          o_irq_id,
  output logic [NUM_IRQ-1:0]  o_pending
);

  irq_state_t          r_state, w_state_nxt;
  logic [NUM_IRQ-1:0]  r_src_prev, r_pending, r_mask;
  logic                r_gen;
  logic [ADDR_W-1:0]   r_vec_base, r_vec, r_epc;
  logic [4:0]          r_irq_id;

  logic [NUM_IRQ-1:0]  w_set, w_clr, w_cand;
  logic                w_cand_valid, w_req, w_boundary, w_arm_latch;
  logic [4:0]          w_win_id;
  logic [ADDR_W-1:0]   w_win_ext, w_vec;

  assign w_set  = i_irq_src & ~r_src_prev;
  assign w_cand = r_pending & r_mask;

  loproc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .i_req   (w_cand),
    .o_valid (w_cand_valid),
    .o_id    (w_win_id)
  );

  assign w_req      = r_gen & w_cand_valid;
  assign w_boundary = i_pc_load && (i_pc_jump == 2'b00) && !i_iret;
  assign w_win_ext  = ADDR_W'(w_win_id);
  assign w_vec      = r_vec_base + (w_win_ext << VEC_SHIFT);

  always_comb begin
    w_clr = '0;
    if (r_state == ST_DISPATCH)
      w_clr = NUM_IRQ'(1) << r_irq_id;
    if (i_cfg_we && (i_cfg_addr == CFG_CLR))
      w_clr = w_clr | i_cfg_wdata[NUM_IRQ-1:0];
  end

  // A new edge in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_prev <= '0;
      r_pending  <= '0;
    end else begin
      r_src_prev <= i_irq_src;
      r_pending  <= (r_pending & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask     <= '0;
      r_gen      <= 1'b0;
      r_vec_base <= VEC_BASE_RST;
    end else if (i_cfg_we) begin
      case (i_cfg_addr)
        CFG_MASK:  r_mask     <= i_cfg_wdata[NUM_IRQ-1:0];
        CFG_VBASE: r_vec_base <= i_cfg_wdata;
        CFG_GEN:   r_gen      <= i_cfg_wdata[0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_latch = 1'b0;
    case (r_state)
      ST_IDLE:     if (w_req) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_boundary) begin
          w_arm_latch = 1'b1;
          w_state_nxt = ST_DISPATCH;
        end
      end
      ST_DISPATCH: w_state_nxt = ST_SERVICE;
      ST_SERVICE:  if (i_iret) w_state_nxt = ST_RETURN;
      ST_RETURN:   w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Vector is frozen here so a later base write cannot disturb this dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_epc    <= '0;
      r_irq_id <= 5'd0;
      r_vec    <= '0;
    end else if (w_arm_latch) begin
      r_epc    <= i_pc_next_addr;
      r_irq_id <= w_win_id;
      r_vec    <= w_vec;
    end
  end

  assign o_irq_interrupt   = (r_state == ST_DISPATCH);
  assign o_irq_vector_addr = o_irq_interrupt ? r_vec : '0;
  assign o_ret_jump        = (r_state == ST_RETURN);
  assign o_ret_addr        = o_ret_jump ? r_epc : '0;
  assign o_irq_active      = (r_state == ST_SERVICE);
  assign o_epc             = r_epc;
  assign o_irq_id          = r_irq_id;
  assign o_pending         = r_pending;

endmodule

// File: doc/loproc_irq_ctrl.md
Name: loproc_irq_ctrl

Overview:
Interrupt sequencer for the loproc program counter. Latches requests from NUM_IRQ sources, masks and prioritises them, and waits for a safe fetch boundary. It then fires a one-cycle interrupt strobe with a vector address into the PC, saves the return address, and replays that address on return-from-interrupt. It sits beside loproc_pc and drives the PC's interrupt and interrupt_addr inputs. ret_jump/ret_addr are OR-muxed with the core's own jump path.

Parameters:
NUM_IRQ, 8, number of interrupt sources (1..32)
ADDR_W, `INSTRUCTION_WIDTH, PC/address width
VEC_SHIFT, 4, log2 bytes per vector slot
VEC_BASE_RST, 'h5000_2000, reset value of vector base register

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
irq_src  in  NUM_IRQ  level request lines (synchronous to clk)
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=enable mask, 1=vector base, 2=global enable (bit0), 3=pending clear (W1C)
cfg_wdata  in  ADDR_W  config write data
pc_load  in  1  PC advancing this cycle (mirrors PC load)
pc_jump  in  2  core jump request to PC this cycle (nonzero = jump in flight)
pc_next_addr  in  ADDR_W  PC next_instr_addr
iret  in  1  return-from-interrupt strobe from decode
irq_interrupt  out  1  one-cycle strobe to PC interrupt input
irq_vector_addr  out  ADDR_W  to PC interrupt_addr; valid while irq_interrupt=1
epc  out  ADDR_W  saved return address
ret_jump  out  1  one-cycle return request to core jump mux
ret_addr  out  ADDR_W  return target (= epc) while ret_jump=1
irq_active  out  1  handler in service
irq_id  out  5  id of in-service (or last serviced) source
pending  out  NUM_IRQ  pending register, for readback

Behaviour:
- Reset (rst_n=0, async): state=IDLE; pending=0; mask=0; gen=0; vec_base=VEC_BASE_RST; epc=0; irq_id=0; all strobes 0.
- Pending capture: irq_src edge detect (registered prev). Bit sets on a 0->1 transition. Bit clears on dispatch of that id or on W1C. If set and clear land on the same cycle, set wins.
- Candidate: cand = pending & mask. Lowest set index wins (fixed priority). req = gen & |cand.
- FSM:
  - IDLE: if req, go to ARM.
  - ARM: wait for a safe boundary: pc_load=1 and pc_jump==0 and iret=0. When reached, latch epc=pc_next_addr, irq_id=winner, and vec=vec_base + (winner<<VEC_SHIFT). Go to DISPATCH. If req drops (mask/W1C/gen), go back to IDLE.
  - DISPATCH (1 cycle): irq_interrupt=1, irq_vector_addr=vec; clear pending[irq_id]; go to SERVICE.
  - SERVICE: irq_active=1; no nesting, new requests only accumulate in pending. On iret, go to RETURN.
  - RETURN (1 cycle): ret_jump=1, ret_addr=epc; go to IDLE. A pending request re-arms from IDLE on the next cycle (min 2 cycles between handler exit and next dispatch).
- Latency: src edge to irq_interrupt is at least 3 cycles (capture, IDLE->ARM, ARM->DISPATCH), longer while pc_load=0 or a jump is in flight.
- iret outside SERVICE is ignored.
- Config writes take effect the next cycle. A vector-base change after ARM latch does not affect the in-flight dispatch.
- Vector address arithmetic is modulo 2^ADDR_W (wraps).
- irq_vector_addr and ret_addr are 0 when their strobe is low.

Decomposition:
- Shared package/defines (loproc_defines.vh):
  - FSM state encodings (IDLE, ARM, DISPATCH, SERVICE, RETURN)
  - cfg_addr register offsets
  - VEC_SHIFT default
- One natural sub-module: loproc_prio_enc (NUM_IRQ-wide lowest-index-first encoder producing valid + 5-bit id).

Test Plan:
- Basic dispatch:
  - Stimulus: mask=0xFF, gen=1, pc_load=1, irq_src[3] rises, pc_next_addr=0x120.
  - Response: irq_interrupt pulses with irq_vector_addr=0x5000_2030, epc=0x120, irq_id=3, pending[3] cleared, irq_active=1.
- Priority:
  - Stimulus: irq_src[5] and irq_src[2] rise together.
  - Response: id 2 dispatched first at 0x5000_2020. After iret, ret_jump=1 with ret_addr=epc. Id 5 then dispatched at 0x5000_2050.
- Safe boundary:
  - Stimulus: pending request while pc_load=0, then pc_jump=1 for one cycle.
  - Response: no irq_interrupt until the first cycle with pc_load=1 and pc_jump=0. epc equals pc_next_addr of that cycle.
- Masking and W1C:
  - Stimulus: irq_src[1] rises with mask[1]=0.
  - Response: pending[1]=1, no dispatch. Setting mask[1] dispatches it. Alternatively, W1C with 0x2 before unmask leaves pending=0 and produces no dispatch.
- No nesting:
  - Stimulus: irq_src[0] rises during SERVICE of id 4.
  - Response: pending[0]=1, no strobe until after RETURN.
- Async reset mid-SERVICE:
  - Stimulus: rst_n low for 3 ns between edges.
  - Response: outputs zero immediately, vec_base=0x5000_2000, mask=0. After release, no dispatch without new edges and config.
